// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and helpers for the pipelined selector
package pipe_ctrl_pkg;

    localparam int DEFAULT_WIDTH     = 5;
    localparam int DEFAULT_RESET_VAL = 0;

    // Control half of a stage record; the data half is sized by each instance.
    typedef struct packed {
        logic valid;
        logic err;
    } stage_flags_t;

    // Select width for an N-input selector, never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - one pipeline register with reset > flush > stall priority
module pipe_stage_reg
    import pipe_ctrl_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               data_en,
    input  logic [WIDTH-1:0]   d_data,
    input  stage_flags_t       d_flags,
    output logic [WIDTH-1:0]   q_data,
    output stage_flags_t       q_flags
);

    // Reset and flush both clear; stall freezes; data_en lets bubbles keep old data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_data  <= RESET_VAL;
            q_flags <= '0;
        end else if (flush) begin
            q_data  <= RESET_VAL;
            q_flags <= '0;
        end else if (!stall) begin
            if (data_en) begin
                q_data <= d_data;
            end
            q_flags <= d_flags;
        end
    end

endmodule

// File: rtl/mux_pipe_sel.sv
// rtl/mux_pipe_sel.sv - N:1 operand select followed by a stallable, flushable pipeline
module mux_pipe_sel
    import pipe_ctrl_pkg::*;
#(
    parameter int          WIDTH     = DEFAULT_WIDTH,
    parameter int          NUM_IN    = 4,
    parameter int          STAGES    = 1,
    parameter int unsigned RESET_VAL = DEFAULT_RESET_VAL,
    localparam int         SEL_W     = sel_width(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic                    out_sel_err
);

    localparam logic [WIDTH-1:0] RST_DATA = WIDTH'(RESET_VAL);

    if (STAGES < 1) begin : g_bad_stages
        $error("mux_pipe_sel: STAGES must be at least 1");
    end
    if (NUM_IN < 2) begin : g_bad_num_in
        $error("mux_pipe_sel: NUM_IN must be at least 2");
    end

    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_ok;

    // Index k 0..STAGES-1 feeds stage k; index STAGES is the last stage output.
    logic [WIDTH-1:0] w_stage_data  [STAGES+1];
    stage_flags_t     w_stage_flags [STAGES+1];

    // Pick the addressed input; an unmatched select yields RESET_VAL and no ok.
    always_comb begin
        w_sel_data = RST_DATA;
        w_sel_ok   = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                w_sel_data = in_data[k*WIDTH +: WIDTH];
                w_sel_ok   = 1'b1;
            end
        end
    end

    assign w_stage_data[0]        = w_sel_data;
    assign w_stage_flags[0].valid = in_valid;
    assign w_stage_flags[0].err   = in_valid & ~w_sel_ok;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        // Only stage 0 skips the data load on bubbles, so idle slots do not toggle the data path.
        pipe_stage_reg #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RST_DATA)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .stall   (stall),
            .flush   (flush),
            .data_en ((i == 0) ? in_valid : 1'b1),
            .d_data  (w_stage_data[i]),
            .d_flags (w_stage_flags[i]),
            .q_data  (w_stage_data[i+1]),
            .q_flags (w_stage_flags[i+1])
        );
    end

    assign out_data    = w_stage_data[STAGES];
    assign out_valid   = w_stage_flags[STAGES].valid;
    assign out_sel_err = w_stage_flags[STAGES].err;

endmodule
